// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand driver: ALU function codes, the
// multiply request code, the driver FSM state encoding and an op decoder.
package alu_pkg;

    localparam logic [2:0] F_AND  = 3'd0;
    localparam logic [2:0] F_OR   = 3'd1;
    localparam logic [2:0] F_ADD  = 3'd2;
    localparam logic [2:0] F_ANDN = 3'd4;
    localparam logic [2:0] F_ORN  = 3'd5;
    localparam logic [2:0] F_SUB  = 3'd6;
    localparam logic [2:0] F_SLT  = 3'd7;

    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Request codes 0-2 and 4-7 map straight onto an ALU F code.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3] == 1'b0) && (op[2:0] != 3'd3);
    endfunction

endpackage

// File: rtl/alu_op_driver_if.sv
// Request/response handshake bundle between a sequencer (master) and the
// ALU operand driver (slave). Optional result flags under ALU_OP_DRIVER_FLAGS_EN.
interface alu_op_driver_if #(
    parameter int unsigned N = 8
);
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_y;
    logic         rsp_cout;
`ifdef ALU_OP_DRIVER_FLAGS_EN
    logic         rsp_zero;
    logic         rsp_neg;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_cout, rsp_zero, rsp_neg
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_cout, rsp_zero, rsp_neg
    );
`else
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_cout
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_cout
    );
`endif
endinterface

// File: rtl/alu_mul_iter.sv
// Shift-and-add multiplier state: accumulator, shifted multiplicand,
// shifted multiplier, step counter and sticky adder carry. The external ALU
// performs the add; next-state values are exported so the parent can
// register the ALU operands in step with these flops.
module alu_mul_iter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         step,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] alu_y,
    input  logic         alu_cout,
    output logic [N-1:0] acc_nxt,
    output logic [N-1:0] addend_nxt,
    output logic         csticky_nxt,
    output logic         done
);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  m_q, m_d;
    logic [N-1:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cs_q, cs_d;

    // Load on start, otherwise advance one partial product per step.
    always_comb begin
        acc_d = acc_q;
        m_d   = m_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        cs_d  = cs_q;
        if (start) begin
            acc_d = '0;
            m_d   = a;
            q_d   = b;
            cnt_d = '0;
            cs_d  = 1'b0;
        end else if (step) begin
            acc_d = alu_y;
            cs_d  = cs_q | (q_q[0] & alu_cout);
            m_d   = m_q << 1;
            q_d   = q_q >> 1;
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign acc_nxt     = acc_d;
    assign addend_nxt  = q_d[0] ? m_d : '0;
    assign csticky_nxt = cs_d;
    assign done        = step && (cnt_q == CW'(N - 1));

    // Multiplier state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            m_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
            cs_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            m_q   <= m_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
            cs_q  <= cs_d;
        end
    end

endmodule

// File: rtl/alu_op_driver.sv
// Initiator for an external combinational ALU: accepts ops on a valid/ready
// request port, drives registered F/a/b, captures the result and returns it
// on a valid/ready response port. Op 8 is an N-step unsigned multiply built
// from repeated ALU adds. Optional macro ALU_OP_DRIVER_FLAGS_EN adds
// rsp_zero/rsp_neg response flags.
module alu_op_driver
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           reset,
    alu_op_driver_if.slave bus,
    output logic           busy,
    output logic [2:0]     alu_F,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    input  logic [N-1:0]   alu_y,
    input  logic           alu_cout
);
    state_e       state_q, state_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [N-1:0] rsp_y_q, rsp_y_d;
    logic         rsp_cout_q, rsp_cout_d;
    logic [2:0]   alu_f_q, alu_f_d;
    logic [N-1:0] alu_a_q, alu_a_d;
    logic [N-1:0] alu_b_q, alu_b_d;

    logic         mul_start, mul_step, mul_done, mul_cs_nxt;
    logic [N-1:0] mul_acc_nxt, mul_addend_nxt;

    alu_mul_iter #(.N(N)) u_mul (
        .clk         (clk),
        .reset       (reset),
        .start       (mul_start),
        .step        (mul_step),
        .a           (bus.req_a),
        .b           (bus.req_b),
        .alu_y       (alu_y),
        .alu_cout    (alu_cout),
        .acc_nxt     (mul_acc_nxt),
        .addend_nxt  (mul_addend_nxt),
        .csticky_nxt (mul_cs_nxt),
        .done        (mul_done)
    );

    // Next state, result capture and ALU operand selection.
    // ALU operands are chosen from the next state so the registered F/a/b
    // are already valid during the first EXEC/MUL cycle. rsp_valid lags the
    // RESP state by one cycle, so rsp_y is settled a cycle before valid.
    always_comb begin
        state_d    = state_q;
        rsp_y_d    = rsp_y_q;
        rsp_cout_d = rsp_cout_q;
        mul_start  = 1'b0;
        mul_step   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (is_alu_op(bus.req_op)) begin
                        state_d = ST_EXEC;
                    end else if (bus.req_op == OP_MUL) begin
                        state_d   = ST_MUL;
                        mul_start = 1'b1;
                    end else begin
                        state_d    = ST_RESP;
                        rsp_y_d    = '0;
                        rsp_cout_d = 1'b0;
                    end
                end
            end
            ST_EXEC: begin
                rsp_y_d    = alu_y;
                rsp_cout_d = alu_cout;
                state_d    = ST_RESP;
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_done) begin
                    state_d    = ST_RESP;
                    rsp_y_d    = mul_acc_nxt;
                    rsp_cout_d = mul_cs_nxt;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rsp_valid_d = (state_q == ST_RESP) && !(rsp_valid_q && bus.rsp_ready);

        alu_f_d = '0;
        alu_a_d = '0;
        alu_b_d = '0;
        if (state_d == ST_EXEC) begin
            alu_f_d = bus.req_op[2:0];
            alu_a_d = bus.req_a;
            alu_b_d = bus.req_b;
        end else if (state_d == ST_MUL) begin
            alu_f_d = F_ADD;
            alu_a_d = mul_acc_nxt;
            alu_b_d = mul_addend_nxt;
        end
    end

`ifdef ALU_OP_DRIVER_FLAGS_EN
    logic rsp_zero_q, rsp_zero_d;
    logic rsp_neg_q, rsp_neg_d;

    // Flags track the value being loaded into rsp_y.
    always_comb begin
        rsp_zero_d = (rsp_y_d == '0);
        rsp_neg_d  = rsp_y_d[N-1];
    end

    // Flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_zero_q <= 1'b0;
            rsp_neg_q  <= 1'b0;
        end else begin
            rsp_zero_q <= rsp_zero_d;
            rsp_neg_q  <= rsp_neg_d;
        end
    end

    assign bus.rsp_zero = rsp_zero_q;
    assign bus.rsp_neg  = rsp_neg_q;
`endif

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_cout_q  <= 1'b0;
            alu_f_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_cout_q  <= rsp_cout_d;
            alu_f_q     <= alu_f_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign alu_F         = alu_f_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Directed bench for alu_op_driver with a behavioural ALU attached:
// table of single ops plus hand sequences for stall and mid-op reset.
module tb_alu_op_driver;
    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         busy;
    logic [2:0]   alu_F;
    logic [N-1:0] alu_a, alu_b, alu_y;
    logic         alu_cout;

    alu_op_driver_if #(.N(N)) bus ();

    alu_op_driver #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .alu_F    (alu_F),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .alu_cout (alu_cout)
    );

    always #5 clk = ~clk;

    // Reference ALU: F[2] inverts b and adds 1; F[1:0] selects AND/OR/ADD/SLT.
    logic [N-1:0] bb;
    logic [N:0]   sum;
    always_comb begin
        bb  = alu_F[2] ? ~alu_b : alu_b;
        sum = {1'b0, alu_a} + {1'b0, bb} + {{N{1'b0}}, alu_F[2]};
        alu_y    = '0;
        alu_cout = 1'b0;
        case (alu_F[1:0])
            2'd0: alu_y = alu_a & bb;
            2'd1: alu_y = alu_a | bb;
            2'd2: begin alu_y = sum[N-1:0]; alu_cout = sum[N]; end
            default: begin alu_y = {{(N-1){1'b0}}, sum[N-1]}; alu_cout = sum[N]; end
        endcase
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] y;
        logic         c;
        int           lat;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl[NV];

    // Issue one op, wait for rsp_valid (bounded), capture, then handshake.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, output logic [N-1:0] y, output logic c,
                          output logic z, output logic n, output int lat);
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        y = bus.rsp_y;
        c = bus.rsp_cout;
`ifdef ALU_OP_DRIVER_FLAGS_EN
        z = bus.rsp_zero;
        n = bus.rsp_neg;
`else
        z = 1'b0;
        n = 1'b0;
`endif
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_req_ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] y;
        logic         c, z, n;
        int           lat;

        //            op     a      b      y      c     lat
        tbl[0]  = '{4'd2,  8'd2,  8'd3,  8'h05, 1'b0, 2};
        tbl[1]  = '{4'd6,  8'd2,  8'd3,  8'hFF, 1'b0, 2};
        tbl[2]  = '{4'd7,  8'd2,  8'd3,  8'h01, 1'b0, 2};
        tbl[3]  = '{4'd8,  8'd13, 8'd11, 8'h8F, 1'b0, 9};
        tbl[4]  = '{4'd8,  8'd200,8'd3,  8'd88, 1'b1, 9};
        tbl[5]  = '{4'd3,  8'd5,  8'd6,  8'h00, 1'b0, 1};
        tbl[6]  = '{4'd12, 8'd5,  8'd6,  8'h00, 1'b0, 1};
        tbl[7]  = '{4'd0,  8'hF0, 8'h3C, 8'h30, 1'b0, 2};
        tbl[8]  = '{4'd1,  8'hF0, 8'h3C, 8'hFC, 1'b0, 2};
        tbl[9]  = '{4'd4,  8'hF0, 8'h3C, 8'hC0, 1'b0, 2};
        tbl[10] = '{4'd5,  8'hF0, 8'h3C, 8'hF3, 1'b0, 2};
        tbl[11] = '{4'd2,  8'h80, 8'h80, 8'h00, 1'b1, 2};
        tbl[12] = '{4'd8,  8'd16, 8'd16, 8'h00, 1'b0, 9};
        tbl[13] = '{4'd8,  8'hFF, 8'd1,  8'hFF, 1'b0, 9};
        tbl[14] = '{4'd15, 8'hAA, 8'h55, 8'h00, 1'b0, 1};

        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_y", 32'(bus.rsp_y), 32'd0);
        chk("rst_rsp_cout", 32'(bus.rsp_cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_alu", {21'd0, alu_F, alu_a, alu_b}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("v%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, y, c, z, n, lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("v%0d_y", i), 32'(y), 32'(tbl[i].y));
            chk($sformatf("v%0d_cout", i), 32'(c), 32'(tbl[i].c));
`ifdef ALU_OP_DRIVER_FLAGS_EN
            chk($sformatf("v%0d_zero", i), 32'(z), 32'(tbl[i].y == '0));
            chk($sformatf("v%0d_neg", i), 32'(n), 32'(tbl[i].y[N-1]));
`endif
        end

        // Stalled response: result must hold, new requests must be refused.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd2;
        bus.req_a     = 8'hFF;
        bus.req_b     = 8'h01;
        @(posedge clk);
        #1;
        bus.req_a = 8'h01;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("stall_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("stall%0d_y", i), 32'(bus.rsp_y), 32'h00);
            chk($sformatf("stall%0d_cout", i), 32'(bus.rsp_cout), 32'd1);
            chk($sformatf("stall%0d_req_ready", i), 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("stall_release_idle", 32'(bus.req_ready), 32'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("stall_no_ghost_valid", 32'(bus.rsp_valid), 32'd0);
            chk("stall_no_ghost_busy", 32'(busy), 32'd0);
        end

        // Reset during the 4th MUL cycle aborts without a response.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd8;
        bus.req_a     = 8'd13;
        bus.req_b     = 8'd11;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("mul_busy", 32'(busy), 32'd1);
        chk("mul_alu_F", 32'(alu_F), 32'd2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_alu", {21'd0, alu_F, alu_a, alu_b}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        run_op("post_abort", 4'd8, 8'd7, 8'd9, y, c, z, n, lat);
        chk("post_abort_lat", 32'(lat), 32'd9);
        chk("post_abort_y", 32'(y), 32'd63);
        chk("post_abort_cout", 32'(c), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
